exception_sequencer: RTL and testbench

//   Multicycle exception handler for the processor datapath. Latches an exception request, writes
//   the return address to EPC, then drives the memory-address mux to the matching vector address.

---
 rtl/exception_sequencer.sv | 175 +++++++++++++++++
 tb/tb_exception_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/exception_sequencer.sv
// exception_sequencer
//   Multicycle exception handler for the processor datapath. It latches an
//   exception request and writes the return address to EPC. It then drives the
//   memory-address mux to the matching vector address. After the memory read
//   latency has elapsed, it passes the handler byte through to the PC register.
//
// Ports
//   clk           rising-edge system clock
//   reset         asynchronous, active-low reset
//   exc_opcode    invalid-opcode request (highest priority)
//   exc_overflow  ALU overflow request
//   exc_div0      divide-by-zero request (lowest priority)
//   pc_in         current PC, latched when a request is accepted
//   mem_data_in   memory read data; the handler address is bits [7:0]
//   busy          high in every non-IDLE state
//   mux_own       high while this block owns the memory-address select
//   mux_sel       vector select: 0110 opcode, 0111 overflow, 1000 div0, 0000 idle
//   epc_wr        one-cycle EPC write strobe
//   epc_out       EPC write data (latched PC minus RETURN_OFFSET, wrapping)
//   pc_wr         one-cycle PC write strobe
//   pc_out        PC write data, zero-extended handler byte
//   cause         latched cause: 00 opcode, 01 overflow, 10 div0
//   done          one-cycle pulse, coincident with pc_wr
module exception_sequencer #(
  parameter int unsigned MEM_LATENCY   = 2,      // legal 1..15
  parameter logic [31:0] RETURN_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic        busy,
  output logic        mux_own,
  output logic [3:0]  mux_sel,
  output logic        epc_wr,
  output logic [31:0] epc_out,
  output logic        pc_wr,
  output logic [31:0] pc_out,
  output logic [1:0]  cause,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SAVE = 2'b01,
    WAIT = 2'b10,
    LOAD = 2'b11
  } state_t;

  localparam logic [1:0] CAUSE_OPCODE   = 2'b00;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'b01;
  localparam logic [1:0] CAUSE_DIV0     = 2'b10;

  // The counter is loaded in SAVE so that WAIT lasts exactly MEM_LATENCY cycles.
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_LATENCY - 1);

  state_t      state;
  state_t      next_state;
  logic [3:0]  wait_cnt;
  logic [31:0] pc_lat;
  logic [1:0]  cause_lat;
  logic        any_req;
  logic [1:0]  req_cause;

  // Only the low byte of memory data is meaningful here.
  logic unused_mem_bits;
  assign unused_mem_bits = &{1'b0, mem_data_in[31:8]};

  assign any_req = exc_opcode | exc_overflow | exc_div0;

  // Fixed priority: opcode > overflow > div0.
  always_comb begin
    req_cause = CAUSE_DIV0;
    if (exc_opcode) begin
      req_cause = CAUSE_OPCODE;
    end else if (exc_overflow) begin
      req_cause = CAUSE_OVERFLOW;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Datapath registers: latched PC, cause and the wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= 4'd0;
      pc_lat    <= 32'd0;
      cause_lat <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            pc_lat    <= pc_in;
            cause_lat <= req_cause;
          end
        end
        SAVE: begin
          wait_cnt <= WAIT_LOAD;
        end
        WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next state and outputs. All outputs are functions of state, so the
  // asynchronous reset forcing IDLE immediately clears every strobe.
  always_comb begin
    next_state = IDLE;
    busy       = 1'b0;
    mux_own    = 1'b0;
    mux_sel    = 4'b0000;
    epc_wr     = 1'b0;
    epc_out    = 32'd0;
    pc_wr      = 1'b0;
    pc_out     = 32'd0;
    done       = 1'b0;

    case (state)
      IDLE: begin
        next_state = any_req ? SAVE : IDLE;
      end
      SAVE: begin
        next_state = WAIT;
        busy       = 1'b1;
        mux_own    = 1'b1;
        epc_wr     = 1'b1;
        epc_out    = pc_lat - RETURN_OFFSET;
      end
      WAIT: begin
        next_state = (wait_cnt == 4'd0) ? LOAD : WAIT;
        busy       = 1'b1;
        mux_own    = 1'b1;
      end
      LOAD: begin
        next_state = IDLE;
        busy       = 1'b1;
        mux_own    = 1'b1;
        pc_wr      = 1'b1;
        done       = 1'b1;
        pc_out     = {24'h0, mem_data_in[7:0]};
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    if (mux_own) begin
      case (cause_lat)
        CAUSE_OPCODE:   mux_sel = 4'b0110;
        CAUSE_OVERFLOW: mux_sel = 4'b0111;
        CAUSE_DIV0:     mux_sel = 4'b1000;
        default:        mux_sel = 4'b0000;
      endcase
    end
  end

  assign cause = cause_lat;

endmodule

// File: tb/tb_exception_sequencer.sv
// Testbench for exception_sequencer: a per-cycle vector table on the default
// MEM_LATENCY=2 build, plus hand sequences for asynchronous reset mid-sequence
// and a MEM_LATENCY=1 build.
module tb_exception_sequencer;

  logic        clk;
  logic        reset;
  logic        exc_opcode;
  logic        exc_overflow;
  logic        exc_div0;
  logic [31:0] pc_in;
  logic [31:0] mem_data_in;

  logic        busy0, own0, ewr0, pwr0, done0;
  logic [3:0]  sel0;
  logic [31:0] epc0, pco0;
  logic [1:0]  cause0;

  logic        busy1, own1, ewr1, pwr1, done1;
  logic [3:0]  sel1;
  logic [31:0] epc1, pco1;
  logic [1:0]  cause1;

  int checks = 0;
  int passes = 0;

  exception_sequencer #(.MEM_LATENCY(2), .RETURN_OFFSET(32'd4)) dut (
    .clk(clk), .reset(reset),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_data_in(mem_data_in),
    .busy(busy0), .mux_own(own0), .mux_sel(sel0),
    .epc_wr(ewr0), .epc_out(epc0), .pc_wr(pwr0), .pc_out(pco0),
    .cause(cause0), .done(done0)
  );

  exception_sequencer #(.MEM_LATENCY(1), .RETURN_OFFSET(32'd4)) dut_l1 (
    .clk(clk), .reset(reset),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_data_in(mem_data_in),
    .busy(busy1), .mux_own(own1), .mux_sel(sel1),
    .epc_wr(ewr1), .epc_out(epc1), .pc_wr(pwr1), .pc_out(pco1),
    .cause(cause1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op, ov, dz;
    logic [31:0] pc, mem;
    logic        busy, own;
    logic [3:0]  sel;
    logic        ewr;
    logic [31:0] epc;
    logic        pwr;
    logic [31:0] pco;
    logic [1:0]  cause;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic op, input logic ov, input logic dz,
                     input logic [31:0] pc, input logic [31:0] mem,
                     input logic b, input logic own, input logic [3:0] sel,
                     input logic ewr, input logic [31:0] epc,
                     input logic pwr, input logic [31:0] pco,
                     input logic [1:0] cs, input logic dn);
    vec_t v;
    v.op = op; v.ov = ov; v.dz = dz; v.pc = pc; v.mem = mem;
    v.busy = b; v.own = own; v.sel = sel; v.ewr = ewr; v.epc = epc;
    v.pwr = pwr; v.pco = pco; v.cause = cs; v.done = dn;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic op, input logic ov, input logic dz,
                        input logic [31:0] pc, input logic [31:0] mem);
    exc_opcode = op; exc_overflow = ov; exc_div0 = dz;
    pc_in = pc; mem_data_in = mem;
  endtask

  initial begin
    int first_pwr;
    int busy_cnt;
    int strobe_cnt;
    int pwr0_at;
    logic ok;

    set_in(0, 0, 0, 32'h0, 32'h0);
    reset = 1'b0;

    // Table: each row is inputs for one cycle and the outputs expected in that
    // cycle (state reached by the preceding edges).
    //   op ov dz  pc            mem            busy own sel ewr epc           pwr pco   cause done
    // Overflow request: 4 busy cycles, EPC 0x3C, handler 0x8C.
    add(0,1,0, 32'h40,  32'h8C,       0,0,4'h0,0,32'h0,        0,32'h0, 2'd0,0);
    add(0,0,0, 32'h40,  32'h8C,       1,1,4'h7,1,32'h3C,       0,32'h0, 2'd1,0);
    add(0,0,0, 32'h40,  32'h8C,       1,1,4'h7,0,32'h0,        0,32'h0, 2'd1,0);
    add(0,0,0, 32'h40,  32'h8C,       1,1,4'h7,0,32'h0,        0,32'h0, 2'd1,0);
    add(0,0,0, 32'h40,  32'h8C,       1,1,4'h7,0,32'h0,        1,32'h8C,2'd1,1);
    add(0,0,0, 32'h40,  32'h8C,       0,0,4'h0,0,32'h0,        0,32'h0, 2'd1,0);
    // Opcode + div0 together: opcode wins.
    add(1,0,1, 32'h100, 32'h55,       0,0,4'h0,0,32'h0,        0,32'h0, 2'd1,0);
    add(0,0,0, 32'h100, 32'h55,       1,1,4'h6,1,32'hFC,       0,32'h0, 2'd0,0);
    add(0,0,0, 32'h100, 32'h55,       1,1,4'h6,0,32'h0,        0,32'h0, 2'd0,0);
    add(0,0,0, 32'h100, 32'h55,       1,1,4'h6,0,32'h0,        0,32'h0, 2'd0,0);
    add(0,0,0, 32'h100, 32'h55,       1,1,4'h6,0,32'h0,        1,32'h55,2'd0,1);
    add(0,0,0, 32'h100, 32'h55,       0,0,4'h0,0,32'h0,        0,32'h0, 2'd0,0);
    // Div0 original request, div0 re-raised during WAIT is ignored.
    add(0,0,1, 32'h200, 32'h33,       0,0,4'h0,0,32'h0,        0,32'h0, 2'd0,0);
    add(0,0,0, 32'h200, 32'h33,       1,1,4'h8,1,32'h1FC,      0,32'h0, 2'd2,0);
    add(0,0,1, 32'h200, 32'h33,       1,1,4'h8,0,32'h0,        0,32'h0, 2'd2,0);
    add(0,0,1, 32'h200, 32'h33,       1,1,4'h8,0,32'h0,        0,32'h0, 2'd2,0);
    add(0,0,0, 32'h200, 32'h33,       1,1,4'h8,0,32'h0,        1,32'h33,2'd2,1);
    add(0,0,0, 32'h200, 32'h33,       0,0,4'h0,0,32'h0,        0,32'h0, 2'd2,0);
    // Opcode request, div0 raised during WAIT: cause and select unchanged.
    add(1,0,0, 32'h300, 32'h44,       0,0,4'h0,0,32'h0,        0,32'h0, 2'd2,0);
    add(0,0,0, 32'h300, 32'h44,       1,1,4'h6,1,32'h2FC,      0,32'h0, 2'd0,0);
    add(0,0,1, 32'h300, 32'h44,       1,1,4'h6,0,32'h0,        0,32'h0, 2'd0,0);
    add(0,0,1, 32'h300, 32'h44,       1,1,4'h6,0,32'h0,        0,32'h0, 2'd0,0);
    add(0,0,0, 32'h300, 32'h44,       1,1,4'h6,0,32'h0,        1,32'h44,2'd0,1);
    add(0,0,0, 32'h300, 32'h44,       0,0,4'h0,0,32'h0,        0,32'h0, 2'd0,0);
    // pc_in=0 wraps EPC; upper memory bits are dropped.
    add(1,0,0, 32'h0,   32'hFFFFFF12, 0,0,4'h0,0,32'h0,        0,32'h0, 2'd0,0);
    add(0,0,0, 32'h0,   32'hFFFFFF12, 1,1,4'h6,1,32'hFFFFFFFC, 0,32'h0, 2'd0,0);
    add(0,0,0, 32'h0,   32'hFFFFFF12, 1,1,4'h6,0,32'h0,        0,32'h0, 2'd0,0);
    add(0,0,0, 32'h0,   32'hFFFFFF12, 1,1,4'h6,0,32'h0,        0,32'h0, 2'd0,0);
    add(0,0,0, 32'h0,   32'hFFFFFF12, 1,1,4'h6,0,32'h0,        1,32'h12,2'd0,1);
    add(0,0,0, 32'h0,   32'hFFFFFF12, 0,0,4'h0,0,32'h0,        0,32'h0, 2'd0,0);

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs",
          {21'd0, busy0, own0, sel0, ewr0, pwr0, done0, cause0},
          32'd0);
    check("reset_data", epc0 | pco0, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven run.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      set_in(vecs[i].op, vecs[i].ov, vecs[i].dz, vecs[i].pc, vecs[i].mem);
      #1;
      checks++;
      ok = (busy0 === vecs[i].busy) && (own0 === vecs[i].own) &&
           (sel0 === vecs[i].sel) && (ewr0 === vecs[i].ewr) &&
           (epc0 === vecs[i].epc) && (pwr0 === vecs[i].pwr) &&
           (pco0 === vecs[i].pco) && (cause0 === vecs[i].cause) &&
           (done0 === vecs[i].done);
      if (ok) begin
        passes++;
      end else begin
        $display("FAIL vec%0d: got busy=%b own=%b sel=%h ewr=%b epc=%h pwr=%b pco=%h cause=%0d done=%b expected busy=%b own=%b sel=%h ewr=%b epc=%h pwr=%b pco=%h cause=%0d done=%b",
                 i, busy0, own0, sel0, ewr0, epc0, pwr0, pco0, cause0, done0,
                 vecs[i].busy, vecs[i].own, vecs[i].sel, vecs[i].ewr, vecs[i].epc,
                 vecs[i].pwr, vecs[i].pco, vecs[i].cause, vecs[i].done);
      end
      $display("vec%0d op=%b ov=%b dz=%b pc=%h -> busy=%b sel=%h epc_wr=%b pc_wr=%b cause=%0d",
               i, vecs[i].op, vecs[i].ov, vecs[i].dz, vecs[i].pc, busy0, sel0, ewr0, pwr0, cause0);
    end

    // Reset asserted during WAIT: outputs drop with no clock edge.
    @(negedge clk);
    set_in(0, 1, 0, 32'h80, 32'h77);
    @(negedge clk);
    set_in(0, 0, 0, 32'h80, 32'h77);
    @(negedge clk);                       // now in first WAIT cycle
    #1;
    check("pre_reset_busy", {31'd0, busy0}, 32'd1);
    #1 reset = 1'b0;                      // mid low phase, well before the next posedge
    #1;
    check("async_reset_busy_own", {30'd0, busy0, own0}, 32'd0);
    check("async_reset_strobes", {24'd0, sel0, ewr0, pwr0, done0, 1'b0}, 32'd0);
    $display("reset mid-WAIT: busy=%b own=%b sel=%h", busy0, own0, sel0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    strobe_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (pwr0 || ewr0 || busy0) strobe_cnt++;
    end
    check("no_activity_after_reset", strobe_cnt, 0);
    $display("after reset release: strobe cycles=%0d", strobe_cnt);
    set_in(1, 0, 0, 32'h90, 32'h21);
    @(negedge clk);
    set_in(0, 0, 0, 32'h90, 32'h21);
    #1;
    check("restart_save_epc_wr", {31'd0, ewr0}, 32'd1);
    check("restart_save_epc", epc0, 32'h8C);
    $display("restart: epc_wr=%b epc=%h", ewr0, epc0);
    repeat (6) @(negedge clk);

    // MEM_LATENCY=1 build: pc_wr in the 3rd cycle after the request edge.
    @(negedge clk);
    set_in(1, 0, 0, 32'h20, 32'hFFFFFF12);
    first_pwr = 0;
    busy_cnt  = 0;
    pwr0_at   = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) exc_opcode = 1'b0;
      #1;
      if (busy1) busy_cnt++;
      if (pwr1 && first_pwr == 0) begin
        first_pwr = k;
        check("l1_pc_out", pco1, 32'h12);
        check("l1_done", {31'd0, done1}, 32'd1);
      end
      if (pwr0 && pwr0_at == 0) pwr0_at = k;
    end
    check("l1_pc_wr_cycle", first_pwr, 3);
    check("l1_busy_cycles", busy_cnt, 3);
    check("l2_pc_wr_cycle", pwr0_at, 4);
    $display("latency: ML1 pc_wr cycle=%0d busy=%0d, ML2 pc_wr cycle=%0d", first_pwr, busy_cnt, pwr0_at);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
